byte_word_packer: RTL and testbench
===================================

# byte_word_packer

Packs an 8-bit byte stream into 32-bit words for the datapath's byte-order stage. The first byte of each word lands in bits [7:0], so a word is little-endian packed when it leaves this block. The downstream big-endian converter takes `out_data` directly on its `din`. A tail of fewer than four bytes, marked by `in_last`, is flushed as a padded partial word with a byte-valid mask.

## Interface
Parameters:
- `PAD_BYTE`, default 8'h00: value written into unused byte lanes of a partial (flushed) word.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `in_valid`  in  1  upstream byte present.
- `in_ready`  out  1  block can accept a byte this cycle.
- `in_data`  in  8  byte payload.
- `in_last`  in  1  byte closes the current word, even if the word is not full (flush).
- `out_valid`  out  1  `out_data` holds a word.
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  32  packed word; byte k of the word is in bits [8k+7:8k].
- `out_keep`  out  4  bit k set means byte lane k holds real data.
- `out_last`  out  1  word was closed by `in_last`.

## Operation
- Accept rule: a byte is accepted when `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready` (combinational). The input stalls whenever the output register is full and not draining, including on bytes that would not complete a word.
- Fill counter `cnt` (2 bits) acts as the state: FILL0 → FILL1 → FILL2 → FILL3. It indexes the byte lane of the next accepted byte.
- Accumulator `acc[23:0]` holds lanes 0..2 of the word being built.
- Accepted byte with `cnt<3` and `in_last=0`:
  - byte is stored in lane `cnt` of `acc`;
  - `cnt` increments by 1.
- Accepted byte with `cnt==3`, or with `in_last=1` at any `cnt`, closes the word. In that cycle:
  - the output register loads `{lanes...}`: accumulated lanes below `cnt`, the current byte in lane `cnt`, and `PAD_BYTE` in every lane above `cnt`;
  - `out_keep` loads `(4'b0010 << cnt) - 1`, i.e. ones in lanes 0..`cnt`;
  - `out_last` loads `in_last`;
  - `cnt` returns to 0 and `acc` clears to 0.
- `in_last` on the 4th byte gives a full word with `out_last=1`.
- Output register:
  - `out_valid` sets on a closing accept;
  - `out_valid` clears on `out_valid && out_ready` unless a closing accept happens in the same cycle, in which case it reloads and stays high.
  - `out_data`, `out_keep` and `out_last` hold stable while `out_valid && !out_ready`.
- Simultaneous drain and close: the old word leaves and the new word loads in the same edge, with no bubble.
- Reset:
  - `out_valid`=0, `out_data`=0, `out_keep`=0, `out_last`=0, `cnt`=0, `acc`=0.
  - `in_ready` is therefore 1 in the first cycle after reset.
  - A partial word in progress is discarded; it is never emitted.
- Reset has priority over any handshake in the same cycle.
- `in_data` and `in_last` are ignored when `in_valid=0`.

## Timing
- Latency: the closing byte is accepted at edge N; `out_valid`=1 with the word after edge N, i.e. one cycle.
- Throughput: one byte per cycle sustained when `out_ready` is held at 1. A full word is emitted every 4 cycles with no idle cycles between words.
- No combinational path from `in_*` to `out_*`. `in_ready` depends combinationally on `out_ready` only.
- `out_*` values are registered and change only on the rising edge of `clk`.

## Test plan
- Byte order: send 44,33,22,11 with `out_ready=1`.
  - Required: one cycle after the 4th accept, `out_data`=32'h11223344, `out_keep`=4'hF, `out_last`=0.
  - Feeding this into the big-endian converter with `en=1` gives 32'h44332211.
- Partial flush: send AA, then BB with `in_last=1`, `PAD_BYTE`=8'h00.
  - Required: `out_data`=32'h0000BBAA, `out_keep`=4'b0011, `out_last`=1, `cnt`=0 afterwards.
- Single-byte flush: `PAD_BYTE`=8'hFF, send 5A with `in_last=1`.
  - Required: `out_data`=32'hFFFFFF5A, `out_keep`=4'b0001.
- Backpressure: complete word 32'h04030201, hold `out_ready=0` for 5 cycles while `in_valid=1`.
  - Required: `in_ready=0`, `out_data` stable and no bytes accepted during those cycles.
  - Raising `out_ready` drains the word and accepts the pending byte in the same cycle.
- Streaming: 12 bytes 00..0B back-to-back with `out_ready=1`.
  - Required: words 32'h03020100, 32'h07060504, 32'h0B0A0908, spaced exactly 4 cycles apart.
- Reset mid-word: send 2 bytes, assert `rst` for one cycle, then send 10,20,30,40.
  - Required: the only word emitted is 32'h40302010 with `out_keep`=4'hF.
  - All outputs read 0 during the cycle after the reset edge.

Source files
------------

// File: rtl/byte_word_packer.sv
// Byte-to-word packer: collects up to four bytes little-endian into a 32-bit
// word, flushing early on in_last with PAD_BYTE filling the unused lanes.
module byte_word_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_keep,
  output logic        out_last
);

  localparam logic [1:0] FILL0 = 2'd0;
  localparam logic [1:0] FILL1 = 2'd1;
  localparam logic [1:0] FILL2 = 2'd2;
  localparam logic [1:0] FILL3 = 2'd3;

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] acc_q, acc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [3:0]  out_keep_q, out_keep_d;
  logic        out_last_q, out_last_d;

  logic        accept;
  logic        close;
  logic [31:0] word;
  logic [3:0]  keep;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign close    = accept && (in_last || (cnt_q == FILL3));
  assign keep     = (4'b0010 << cnt_q) - 4'd1;

  // Lanes below cnt come from the accumulator, lane cnt is the live byte,
  // lanes above cnt are padding.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      if (gi < 3) begin : g_acc_lane
        assign word[8*gi +: 8] = (2'(gi) < cnt_q)  ? acc_q[8*gi +: 8] :
                                 (2'(gi) == cnt_q) ? in_data : PAD_BYTE;
      end else begin : g_top_lane
        assign word[8*gi +: 8] = (cnt_q == FILL3) ? in_data : PAD_BYTE;
      end
    end
  endgenerate

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (close) begin
      out_valid_d = 1'b1;
      out_data_d  = word;
      out_keep_d  = keep;
      out_last_d  = in_last;
      cnt_d       = FILL0;
      acc_d       = 24'd0;
    end else if (accept) begin
      acc_d[{cnt_q, 3'b000} +: 8] = in_data;
      case (cnt_q)
        FILL0:   cnt_d = FILL1;
        FILL1:   cnt_d = FILL2;
        FILL2:   cnt_d = FILL3;
        default: cnt_d = FILL0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= FILL0;
      acc_q       <= 24'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_keep_q  <= 4'd0;
      out_last_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_byte_word_packer.sv
// Bench for byte_word_packer: two instances (pad 00 and pad FF) share one
// stimulus stream and are compared every cycle against a byte-queue model.
module tb_byte_word_packer;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_last, out_ready;
  logic [7:0]  in_data;
  logic        rdy0, rdy1, ov0, ov1, ol0, ol1;
  logic [31:0] od0, od1;
  logic [3:0]  ok0, ok1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  byte unsigned m_bytes[$];
  logic         m_valid;
  logic [31:0]  m_data0, m_data1;
  logic [3:0]   m_keep;
  logic         m_last;

  always #5 clk = ~clk;

  byte_word_packer #(.PAD_BYTE(8'h00)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_last(in_last), .out_valid(ov0),
    .out_ready(out_ready), .out_data(od0), .out_keep(ok0), .out_last(ol0)
  );

  byte_word_packer #(.PAD_BYTE(8'hFF)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_last(in_last), .out_valid(ov1),
    .out_ready(out_ready), .out_data(od1), .out_keep(ok1), .out_last(ol1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit acc, cls;
    if (rst) begin
      m_bytes.delete();
      m_valid = 1'b0; m_data0 = '0; m_data1 = '0; m_keep = '0; m_last = 1'b0;
      return;
    end
    acc = in_valid && (!m_valid || out_ready);
    cls = acc && (in_last || m_bytes.size() == 3);
    if (m_valid && out_ready) begin
      $display("word data=%08h keep=%h last=%0d", m_data0, m_keep, m_last);
      m_valid = 1'b0;
    end
    if (acc) m_bytes.push_back(in_data);
    if (cls) begin
      for (int k = 0; k < 4; k++) begin
        m_data0[8*k +: 8] = (k < m_bytes.size()) ? m_bytes[k] : 8'h00;
        m_data1[8*k +: 8] = (k < m_bytes.size()) ? m_bytes[k] : 8'hFF;
        m_keep[k]         = (k < m_bytes.size());
      end
      m_last  = in_last;
      m_valid = 1'b1;
      m_bytes.delete();
    end
  endtask

  task automatic compare_all();
    check("valid0", 32'(ov0), 32'(m_valid));
    check("valid1", 32'(ov1), 32'(m_valid));
    if (m_valid) begin
      check("data0", od0, m_data0);
      check("data1", od1, m_data1);
      check("keep0", 32'(ok0), 32'(m_keep));
      check("keep1", 32'(ok1), 32'(m_keep));
      check("last0", 32'(ol0), 32'(m_last));
      check("last1", 32'(ol1), 32'(m_last));
    end
  endtask

  // Drive one cycle of inputs starting just after a falling edge.
  task automatic step(input logic r, input logic v, input logic [7:0] d,
                      input logic l, input logic ordy);
    rst = r; in_valid = v; in_data = d; in_last = l; out_ready = ordy;
    #1;
    if (!r) begin
      check("in_ready0", 32'(rdy0), 32'(!m_valid || ordy));
      check("in_ready1", 32'(rdy1), 32'(!m_valid || ordy));
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    step(1'b0, 1'b1, d, l, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    m_valid = 1'b0; m_data0 = '0; m_data1 = '0; m_keep = '0; m_last = 1'b0;
    @(negedge clk);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_valid", 32'(ov0), 32'd0);
    check("rst_data", od0, 32'd0);
    rst = 1'b0; #1;
    check("rst_in_ready", 32'(rdy0), 32'd1);

    // Byte order
    send(8'h44, 1'b0); send(8'h33, 1'b0); send(8'h22, 1'b0); send(8'h11, 1'b0);
    check("order_data", od0, 32'h11223344);
    check("order_keep", 32'(ok0), 32'hF);
    check("order_last", 32'(ol0), 32'd0);

    // Partial flush and single-byte flush
    send(8'hAA, 1'b0); send(8'hBB, 1'b1);
    check("part_data0", od0, 32'h0000BBAA);
    check("part_data1", od1, 32'hFFFFBBAA);
    check("part_keep", 32'(ok0), 32'h3);
    check("part_last", 32'(ol0), 32'd1);
    send(8'h5A, 1'b1);
    check("single_data1", od1, 32'hFFFFFF5A);
    check("single_keep", 32'(ok1), 32'h1);

    // Backpressure
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'h05, 1'b0, 1'b0);
      check("bp_in_ready", 32'(rdy0), 32'd0);
      check("bp_data", od0, 32'h04030201);
    end
    step(1'b0, 1'b1, 8'h05, 1'b0, 1'b1);
    check("bp_drained", 32'(ov0), 32'd0);
    send(8'h06, 1'b1);
    check("bp_pending", od0, 32'h00000605);

    // Streaming
    for (int i = 0; i < 12; i++) begin
      send(8'(i), 1'b0);
      check("stream_valid", 32'(ov0), 32'(i % 4 == 3));
      if (i == 3)  check("stream_w0", od0, 32'h03020100);
      if (i == 7)  check("stream_w1", od0, 32'h07060504);
      if (i == 11) check("stream_w2", od0, 32'h0B0A0908);
    end

    // Reset mid-word
    send(8'hC1, 1'b0); send(8'hC2, 1'b0);
    step(1'b1, 1'b1, 8'hC3, 1'b0, 1'b1);
    check("midrst_valid", 32'(ov0), 32'd0);
    check("midrst_data", od0, 32'd0);
    check("midrst_keep", 32'(ok0), 32'd0);
    check("midrst_last", 32'(ol0), 32'd0);
    send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'h30, 1'b0);
    check("midrst_novalid", 32'(ov0), 32'd0);
    send(8'h40, 1'b0);
    check("midrst_word", od0, 32'h40302010);
    check("midrst_wkeep", 32'(ok0), 32'hF);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
           8'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
